// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
// Shared types and constants for the logic_unit_seq block.
//   op_e      : function-select encodings (3 bits)
//   state_e   : sweep engine states
//   NUM_OPS   : number of logic functions
//   SWEEP_LEN : number of vectors replayed by one sweep (NUM_OPS * 4)
//   gate_bit  : one-bit evaluation of a selected logic function
package logic_unit_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOTA = 3'd6,
      OP_NOTB = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NUM_OPS   = 8;
   localparam int SWEEP_LEN = 32;
   localparam int IDX_W     = $clog2(SWEEP_LEN);

   function automatic logic gate_bit(input logic x, input logic y, input op_e op);
      logic r;
      case (op)
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_NAND: r = ~(x & y);
         OP_NOR:  r = ~(x | y);
         OP_XOR:  r = x ^ y;
         OP_XNOR: r = ~(x ^ y);
         OP_NOTA: r = ~x;
         OP_NOTB: r = ~y;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_unit_func.sv
// logic_unit_func
// Purely combinational bitwise logic function unit.
// Ports:
//   a, b   in  WIDTH  operands
//   op     in  3      function select (see op_e)
//   result out WIDTH  f(a, b, op), evaluated independently per bit
module logic_unit_func
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result
);

   op_e op_sel;
   assign op_sel = op_e'(op);

   // No carries between bits, so each bit is an independent gate.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign result[gi] = gate_bit(a[gi], b[gi], op_sel);
      end
   endgenerate

endmodule

// File: rtl/logic_unit_seq.sv
// logic_unit_seq
// Registered eight-function bitwise logic unit with a valid/ready output
// register and an optional self-exercising sweep engine.
// Build option: define LOGIC_UNIT_SWEEP_EN to enable the sweep engine;
// without it the sweep ports remain but are inert.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous reset, active low
//   a, b         in   WIDTH-bit operands
//   op           in   function select (0 AND .. 7 NOT B)
//   in_valid     in   a/b/op valid
//   in_ready     out  block accepts a/b/op this cycle (combinational)
//   out_data     out  registered result
//   out_op       out  op that produced out_data
//   out_valid    out  out_data valid
//   out_ready    in   downstream accepts out_data
//   sweep_start  in   pulse: start a sweep (ignored unless in IDLE)
//   sweep_busy   out  sweep in progress
//   sweep_done   out  one-cycle pulse at sweep end
module logic_unit_seq
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_op,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done
);

   logic [WIDTH-1:0] out_data_reg;
   logic [2:0]       out_op_reg;
   logic             out_valid_reg;

   logic             slot_free;
   logic             ext_load;
   logic             sweep_load;
   logic             sweep_sel;
   logic [WIDTH-1:0] sweep_a;
   logic [WIDTH-1:0] sweep_b;
   logic [2:0]       sweep_op;

   logic [WIDTH-1:0] mux_a;
   logic [WIDTH-1:0] mux_b;
   logic [2:0]       mux_op;
   logic [WIDTH-1:0] func_result;

   assign slot_free = !out_valid_reg || out_ready;

`ifdef LOGIC_UNIT_SWEEP_EN
   state_e           state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             accept_ok;
   logic             busy;
   logic             done_pulse;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      accept_ok  = 1'b0;
      busy       = 1'b0;
      done_pulse = 1'b0;
      sweep_sel  = 1'b0;
      sweep_load = 1'b0;
      case (state_reg)
         IDLE: begin
            // An external accept in the start cycle is still honoured.
            accept_ok = slot_free;
            if (sweep_start) begin
               state_next = RUN;
               idx_next   = '0;
            end
         end
         RUN: begin
            busy      = 1'b1;
            sweep_sel = 1'b1;
            if (slot_free) begin
               sweep_load = 1'b1;
               idx_next   = idx_reg + 1'b1;
               if (idx_reg == IDX_W'(SWEEP_LEN - 1)) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            busy       = 1'b1;
            done_pulse = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Vector layout: idx[4:2] selects the function, idx[1]/idx[0] are
   // replicated across all bits of a/b.
   assign sweep_op = idx_reg[4:2];
   assign sweep_a  = {WIDTH{idx_reg[1]}};
   assign sweep_b  = {WIDTH{idx_reg[0]}};

   // Gating with rst_n makes reset abort a sweep in the same cycle.
   assign in_ready   = rst_n && accept_ok;
   assign sweep_busy = rst_n && busy;
   assign sweep_done = rst_n && done_pulse;
`else
   logic unused_sweep_start;
   assign unused_sweep_start = sweep_start;

   assign sweep_sel  = 1'b0;
   assign sweep_load = 1'b0;
   assign sweep_op   = '0;
   assign sweep_a    = '0;
   assign sweep_b    = '0;
   assign in_ready   = rst_n && slot_free;
   assign sweep_busy = 1'b0;
   assign sweep_done = 1'b0;
`endif

   // in_ready is low while the sweep runs, so the two load sources never
   // coincide and one operand mux suffices.
   assign ext_load = in_valid && in_ready;
   assign mux_a    = sweep_sel ? sweep_a  : a;
   assign mux_b    = sweep_sel ? sweep_b  : b;
   assign mux_op   = sweep_sel ? sweep_op : op;

   logic_unit_func #(
      .WIDTH (WIDTH)
   ) u_func (
      .a      (mux_a),
      .b      (mux_b),
      .op     (mux_op),
      .result (func_result)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_op_reg    <= '0;
         out_valid_reg <= 1'b0;
      end else if (ext_load || sweep_load) begin
         // A load in the same cycle as a drain simply replaces the entry.
         out_data_reg  <= func_result;
         out_op_reg    <= mux_op;
         out_valid_reg <= 1'b1;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_data  = out_data_reg;
   assign out_op    = out_op_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_logic_unit_seq.sv
module tb_logic_unit_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b;
   logic [2:0] op;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic [2:0] out_op;
   logic       out_valid;
   logic       out_ready;
   logic       sweep_start;
   logic       sweep_busy;
   logic       sweep_done;

   always #5 clk = ~clk;

   logic_unit_seq #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a),
      .b           (b),
      .op          (op),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_op      (out_op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done)
   );

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   pops  = 0;
   int   done_cnt = 0;
   logic       snap_valid;
   logic [7:0] snap_data;
   logic       snap_in_ready;

   function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] f);
      case (f)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return ~(x & y);
         3'd3: return ~(x | y);
         3'd4: return x ^ y;
         3'd5: return ~(x ^ y);
         3'd6: return ~x;
         default: return ~y;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_sweep();
      for (int i = 0; i < 32; i++) begin
         logic [4:0] v;
         exp_t e;
         v = 5'(i);
         e.op   = v[4:2];
         e.data = model({8{v[1]}}, {8{v[0]}}, v[4:2]);
         sb.push_back(e);
      end
   endtask

   // One clock: sample at negedge (scoreboard push/pop), then return 1 time
   // unit after the rising edge so the caller can drive new inputs.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      snap_valid    = out_valid;
      snap_data     = out_data;
      snap_in_ready = in_ready;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", {21'd0, out_op, out_data}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            pops++;
            check("sb_data", out_data, e.data);
            check("sb_op", out_op, e.op);
            $display("[TB] out op=%0d data=%02h exp=%02h", out_op, out_data, e.data);
         end
      end
      if (in_valid && in_ready) begin
         e.op   = op;
         e.data = model(a, b, op);
         sb.push_back(e);
         $display("[TB] in  op=%0d a=%02h b=%02h", op, a, b);
      end
      if (sweep_busy && in_ready) check("in_ready_in_sweep", in_ready, 1'b0);
      if (sweep_done) done_cnt++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] tbl [8];
      int p0, d0, n;
      tbl[0] = 8'hC0; tbl[1] = 8'hFC; tbl[2] = 8'h3F; tbl[3] = 8'h03;
      tbl[4] = 8'h3C; tbl[5] = 8'hC3; tbl[6] = 8'h0F; tbl[7] = 8'h33;

      rst_n = 1'b0; a = '0; b = '0; op = '0; in_valid = 1'b0;
      out_ready = 1'b1; sweep_start = 1'b0;
      #1;
      cycle(); cycle();
      check("rst_in_ready", snap_in_ready, 1'b0);
      cycle();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_op", out_op, 3'd0);
      check("rst_busy", sweep_busy, 1'b0);
      check("rst_done", sweep_done, 1'b0);
      rst_n = 1'b1;
      cycle();
      check("idle_in_ready", snap_in_ready, 1'b1);

      // All eight functions, one per cycle, one-cycle latency.
      for (int k = 0; k <= 8; k++) begin
         if (k < 8) begin
            a = 8'hF0; b = 8'hCC; op = 3'(k); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         cycle();
         if (k > 0) begin
            check("func_valid", snap_valid, 1'b1);
            check("func_data", snap_data, tbl[k-1]);
         end
      end
      cycle();
      check("drained", snap_valid, 1'b0);

      // Backpressure: hold result, ignore operand changes.
      out_ready = 1'b0;
      a = 8'hAA; b = 8'h55; op = 3'd1; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0; a = 8'h00; b = 8'h00;
      cycle();
      check("hold_data", snap_data, 8'hFF);
      check("hold_valid", snap_valid, 1'b1);
      check("hold_in_ready", snap_in_ready, 1'b0);
      in_valid = 1'b1; op = 3'd0;
      cycle();
      check("hold_data2", snap_data, 8'hFF);
      in_valid = 1'b0;
      p0 = pops;
      out_ready = 1'b1;
      cycle();
      cycle();
      check("hold_consumed_once", pops - p0, 1);
      check("hold_empty", snap_valid, 1'b0);

      // Back-to-back: four loads, four results with no bubbles.
      p0 = pops;
      for (int k = 0; k < 4; k++) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
         in_valid = 1'b1;
         cycle();
         if (k > 0) check("b2b_valid", snap_valid, 1'b1);
      end
      in_valid = 1'b0;
      cycle();
      check("b2b_valid_last", snap_valid, 1'b1);
      cycle();
      check("b2b_count", pops - p0, 4);
      check("b2b_sb_empty", sb.size(), 0);

`ifdef LOGIC_UNIT_SWEEP_EN
      // Full sweep, out_ready held high.
      p0 = pops; d0 = done_cnt;
      sweep_start = 1'b1;
      push_sweep();
      cycle();
      sweep_start = 1'b0;
      n = 0;
      while ((sweep_busy || sb.size() != 0) && n < 100) begin cycle(); n++; end
      cycle();
      check("sweep_timeout", n < 100, 1'b1);
      check("sweep_count", pops - p0, 32);
      check("sweep_done_once", done_cnt - d0, 1);

      // Sweep with out_ready toggling every cycle.
      p0 = pops; d0 = done_cnt;
      sweep_start = 1'b1;
      push_sweep();
      cycle();
      sweep_start = 1'b0;
      n = 0;
      while ((sweep_busy || sb.size() != 0) && n < 200) begin
         out_ready = ~out_ready;
         cycle(); n++;
      end
      out_ready = 1'b1;
      cycle();
      check("tog_timeout", n < 200, 1'b1);
      check("tog_count", pops - p0, 32);
      check("tog_done_once", done_cnt - d0, 1);

      // Reset in the middle of a sweep.
      p0 = pops; d0 = done_cnt;
      sweep_start = 1'b1;
      push_sweep();
      cycle();
      sweep_start = 1'b0;
      n = 0;
      while (pops - p0 < 10 && n < 50) begin cycle(); n++; end
      rst_n = 1'b0;
      cycle();
      check("abort_busy", sweep_busy, 1'b0);
      check("abort_in_ready", snap_in_ready, 1'b0);
      sb.delete();
      cycle();
      check("abort_out_valid", out_valid, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) cycle();
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_idle_busy", sweep_busy, 1'b0);

      // Restart begins again at idx 0.
      p0 = pops;
      sweep_start = 1'b1;
      push_sweep();
      cycle();
      sweep_start = 1'b0;
      n = 0;
      while ((sweep_busy || sb.size() != 0) && n < 100) begin cycle(); n++; end
      cycle();
      check("restart_count", pops - p0, 32);
      check("restart_done_once", done_cnt - d0, 1);
`else
      // Sweep disabled: the start pulse must do nothing.
      p0 = pops; d0 = done_cnt;
      sweep_start = 1'b1;
      cycle();
      sweep_start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (sweep_busy) check("nosweep_busy", sweep_busy, 1'b0);
      end
      check("nosweep_no_output", pops - p0, 0);
      check("nosweep_no_done", done_cnt - d0, 0);
      check("nosweep_in_ready", snap_in_ready, 1'b1);
`endif

      check("final_sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
